// File: rtl/systolic_pkg.sv
// Shared types for the systolic array scheduler: FSM state encoding and
// the step-counter width helper (sized to count 0..2N-2).
package systolic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int DEF_N = 4;

  function automatic int step_w(input int n);
    return (n < 2) ? 1 : $clog2(2 * n - 1);
  endfunction

  localparam int STEP_W = step_w(DEF_N);

endpackage

// File: rtl/systolic_edge_skew.sv
// Builds one skewed edge vector from an NxN operand buffer and step t.
// Lane i carries element (i, t-i) row-major, or (t-i, i) when COL_MAJOR=1.
module systolic_edge_skew #(
  parameter int N         = 4,
  parameter int WIDTH     = 4,
  parameter int TW        = 3,
  parameter bit COL_MAJOR = 1'b0
) (
  input  logic                             en,
  input  logic [TW-1:0]                    t,
  input  logic [N-1:0][N-1:0][WIDTH-1:0]   buf_i,
  output logic [N-1:0][WIDTH-1:0]          edge_o
);

  localparam int IW = (N < 2) ? 1 : $clog2(N);

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [TW-1:0] w_diff;
    logic [IW-1:0] w_k;
    logic          w_hit;

    assign w_diff = t - TW'(i);
    assign w_hit  = en && (t >= TW'(i)) && (w_diff < TW'(N));
    assign w_k    = w_diff[IW-1:0];

    if (COL_MAJOR) begin : g_col
      assign edge_o[i] = w_hit ? buf_i[w_k][i] : '0;
    end else begin : g_row
      assign edge_o[i] = w_hit ? buf_i[i][w_k] : '0;
    end
  end

endmodule

// File: rtl/systolic_sched.sv
// Systolic-array matrix-multiply scheduler: operand buffers, CLEAR/STREAM/DRAIN
// sequencing and skewed edge feeds. Optional abort input: SYSTOLIC_SCHED_ABORT_EN.
module systolic_sched
  import systolic_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
`ifdef SYSTOLIC_SCHED_ABORT_EN
  input  logic                      abort,
`endif
  input  logic                      start,
  input  logic                      wr_en,
  input  logic                      wr_sel,
  input  logic [$clog2(N)-1:0]      wr_row,
  input  logic [$clog2(N)-1:0]      wr_col,
  input  logic [WIDTH-1:0]          wr_data,
  output logic                      busy,
  output logic                      done,
  output logic                      pe_en,
  output logic                      pe_clr,
  output logic [N-1:0][WIDTH-1:0]   x_edge,
  output logic [N-1:0][WIDTH-1:0]   y_edge,
  output state_t                    dbg_state
);

  localparam int            TW     = step_w(N);
  localparam logic [TW-1:0] T_LAST = TW'(2 * N - 2);
  localparam logic [TW-1:0] D_LAST = TW'(N - 2);

  state_t                         r_state, w_state_nxt;
  logic [TW-1:0]                  r_cnt, w_cnt_nxt;
  logic [N-1:0][N-1:0][WIDTH-1:0] r_buf_a, r_buf_b;
  logic                           r_busy, r_done, r_pe_en, r_pe_clr;
  logic [N-1:0][WIDTH-1:0]        r_x, r_y;
  logic [N-1:0][WIDTH-1:0]        w_x, w_y;
  logic                           w_idle, w_stream, w_abort;

  // Handshake: start is a level sampled at the clock edge and is accepted
  // only while fully idle (internal IDLE and not showing the DONE cycle);
  // any other start is dropped, never queued. done is a single-cycle pulse.
  assign w_idle   = (r_state == ST_IDLE) && !r_busy;
  assign w_stream = (r_state == ST_STREAM);

`ifdef SYSTOLIC_SCHED_ABORT_EN
  assign w_abort = abort && ((r_state == ST_CLEAR) || (r_state == ST_STREAM) ||
                             (r_state == ST_DRAIN));
`else
  assign w_abort = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_idle && start) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      ST_CLEAR: begin
        w_state_nxt = ST_STREAM;
        w_cnt_nxt   = '0;
      end
      ST_STREAM: begin
        if (r_cnt == T_LAST) begin
          w_state_nxt = ST_DRAIN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (r_cnt == D_LAST) begin
          w_state_nxt = ST_DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (w_abort) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Operand buffers keep their contents across reset.
  always_ff @(posedge clk) begin
    if (wr_en && w_idle) begin
      if (wr_sel) r_buf_b[wr_row][wr_col] <= wr_data;
      else        r_buf_a[wr_row][wr_col] <= wr_data;
    end
  end

  systolic_edge_skew #(.N(N), .WIDTH(WIDTH), .TW(TW), .COL_MAJOR(1'b0)) u_skew_a (
    .en     (w_stream),
    .t      (r_cnt),
    .buf_i  (r_buf_a),
    .edge_o (w_x)
  );

  systolic_edge_skew #(.N(N), .WIDTH(WIDTH), .TW(TW), .COL_MAJOR(1'b1)) u_skew_b (
    .en     (w_stream),
    .t      (r_cnt),
    .buf_i  (r_buf_b),
    .edge_o (w_y)
  );

  // Outputs are registered decodes of the current state, so every visible
  // phase trails the internal state by one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n || w_abort) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pe_en  <= 1'b0;
      r_pe_clr <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
    end else begin
      r_busy   <= (r_state != ST_IDLE);
      r_done   <= (r_state == ST_DONE);
      r_pe_en  <= (r_state == ST_STREAM) || (r_state == ST_DRAIN);
      r_pe_clr <= (r_state == ST_CLEAR);
      r_x      <= w_x;
      r_y      <= w_y;
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign pe_en     = r_pe_en;
  assign pe_clr    = r_pe_clr;
  assign x_edge    = r_x;
  assign y_edge    = r_y;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_systolic_sched.sv
// Self-checking bench for systolic_sched (N=4, WIDTH=4): per-cycle job
// expectations from a control table plus an operand model, via a queue.
module tb_systolic_sched;
  import systolic_pkg::*;

  localparam int N    = 4;
  localparam int W    = 4;
  localparam int RW   = 4 + 2 * N * W;
  localparam int JOBC = 14;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic                 wr_en = 1'b0;
  logic                 wr_sel = 1'b0;
  logic [1:0]           wr_row = '0;
  logic [1:0]           wr_col = '0;
  logic [W-1:0]         wr_data = '0;
  logic                 busy, done, pe_en, pe_clr;
  logic [N-1:0][W-1:0]  x_edge, y_edge;
  state_t               dbg_state;
`ifdef SYSTOLIC_SCHED_ABORT_EN
  logic                 abort = 1'b0;
`endif

  always #5 clk = ~clk;

  systolic_sched #(.N(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef SYSTOLIC_SCHED_ABORT_EN
    .abort     (abort),
`endif
    .start     (start),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_row    (wr_row),
    .wr_col    (wr_col),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .pe_en     (pe_en),
    .pe_clr    (pe_clr),
    .x_edge    (x_edge),
    .y_edge    (y_edge),
    .dbg_state (dbg_state)
  );

  int errors = 0;
  int checks = 0;

  logic [W-1:0]  ma [N][N];
  logic [W-1:0]  mb [N][N];
  logic [RW-1:0] exp_q[$];

  typedef struct {
    logic busy;
    logic done;
    logic pe_en;
    logic pe_clr;
  } ctl_vec_t;
  ctl_vec_t ctl_tab [JOBC];

  function automatic logic [RW-1:0] actual();
    return {busy, done, pe_en, pe_clr, x_edge, y_edge};
  endfunction

  // Expected outputs k edges after the edge that samples start.
  function automatic logic [RW-1:0] exp_rec(int k);
    logic [N-1:0][W-1:0] xv, yv;
    int t;
    xv = '0;
    yv = '0;
    if (k >= 2 && k <= 2 * N) begin
      t = k - 2;
      for (int i = 0; i < N; i++) begin
        if (t - i >= 0 && t - i <= N - 1) begin
          xv[i] = ma[i][t-i];
          yv[i] = mb[t-i][i];
        end
      end
    end
    return {ctl_tab[k].busy, ctl_tab[k].done, ctl_tab[k].pe_en, ctl_tab[k].pe_clr, xv, yv};
  endfunction

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write_elem(input bit sel, input int r, input int c, input logic [W-1:0] d);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_row  = 2'(r);
    wr_col  = 2'(c);
    wr_data = d;
    tick();
    wr_en = 1'b0;
    if (sel) mb[r][c] = d;
    else     ma[r][c] = d;
  endtask

  // mode 0: plain job; 1: start + write of A[0][0] during STREAM t=2;
  // 2: start held in the DONE cycle.
  task automatic run_job(input int mode);
    int n_en, n_clr, first_en, clr_at;
    logic [RW-1:0] e;
    n_en = 0; n_clr = 0; first_en = -1; clr_at = -1;
    for (int k = 0; k < JOBC; k++) exp_q.push_back(exp_rec(k));
    start = 1'b1;
    for (int k = 0; k < JOBC; k++) begin
      tick();
      e = exp_q.pop_front();
      check($sformatf("job_m%0d_cyc%0d", mode, k + 1), actual(), e);
      if (pe_en) begin
        n_en++;
        if (first_en < 0) first_en = k;
      end
      if (pe_clr) begin
        n_clr++;
        clr_at = k;
      end
      start = 1'b0;
      wr_en = 1'b0;
      if (mode == 1 && k == 4) begin
        start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0;
        wr_row = 2'd0; wr_col = 2'd0; wr_data = 4'd15;
      end
      if (mode == 2 && k == 12) start = 1'b1;
    end
    start = 1'b0;
    wr_en = 1'b0;
    check($sformatf("pe_en_count_m%0d", mode), RW'(n_en), RW'(2 * N - 1 + N - 1));
    check($sformatf("pe_clr_count_m%0d", mode), RW'(n_clr), RW'(1));
    check($sformatf("clr_before_en_m%0d", mode), RW'(clr_at >= 0 && clr_at < first_en), RW'(1));
    repeat (3) tick();
    check($sformatf("idle_after_m%0d", mode), actual(), '0);
  endtask

  initial begin
    int n_done;
    ctl_tab[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    ctl_tab[1] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int k = 2; k <= 11; k++) ctl_tab[k] = '{1'b1, 1'b0, 1'b1, 1'b0};
    ctl_tab[12] = '{1'b1, 1'b1, 1'b0, 1'b0};
    ctl_tab[13] = '{1'b0, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0;
    repeat (3) tick();
    check("reset_outputs", actual(), '0);
    rst_n = 1'b1;
    tick();

    // A = identity, B[k][j] = k + j
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        write_elem(1'b0, r, c, (r == c) ? 4'd1 : 4'd0);
        write_elem(1'b1, r, c, 4'(r + c));
      end
    run_job(0);
    run_job(1);
    run_job(0);
    run_job(2);

    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        write_elem(1'b0, r, c, 4'($urandom_range(0, 15)));
        write_elem(1'b1, r, c, 4'($urandom_range(0, 15)));
      end
    run_job(0);

    // Reset in the first visible DRAIN cycle.
    start = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      start = 1'b0;
    end
    check("pre_reset_drain", actual(), {1'b1, 1'b0, 1'b1, 1'b0, {(2 * N * W){1'b0}}});
    rst_n = 1'b0;
    tick();
    check("reset_in_drain", actual(), '0);
    rst_n = 1'b1;
    n_done = 0;
    repeat (14) begin
      tick();
      if (done || busy) n_done++;
    end
    check("no_done_after_reset", RW'(n_done), '0);
    run_job(0);

`ifdef SYSTOLIC_SCHED_ABORT_EN
    start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      start = 1'b0;
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle", actual(), '0);
    n_done = 0;
    repeat (14) begin
      tick();
      if (done || busy) n_done++;
    end
    check("abort_no_done", RW'(n_done), '0);
    run_job(0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
